dm_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the byte-addressed data memory (dm).

---
 rtl/dm_arb_pkg.sv | 51 +++++
 rtl/dm_arb_if.sv | 56 +++++
 rtl/dm_arb_rr.sv | 23 ++
 rtl/dm_port_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Package dm_arb_pkg: shared definitions for the data-memory port arbiter.
//  - Request size codes (SZ_*), dm write-op (DM_WR_*) and read-op (DM_RD_*) codes.
//  - Arbiter FSM state enum.
//  - Helpers: size -> dm write op, size/sign -> dm read op, alignment check.
package dm_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] DM_WR_BYTE = 2'b00;
    localparam logic [1:0] DM_WR_HALF = 2'b01;
    localparam logic [1:0] DM_WR_WORD = 2'b10;

    localparam logic [2:0] DM_RD_LBU = 3'b000;
    localparam logic [2:0] DM_RD_LB  = 3'b001;
    localparam logic [2:0] DM_RD_LHU = 3'b010;
    localparam logic [2:0] DM_RD_LH  = 3'b011;
    localparam logic [2:0] DM_RD_LW  = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } state_e;

    // Reserved size is treated as a word access.
    function automatic logic [1:0] wr_op_of(input logic [1:0] size);
        unique case (size)
            SZ_BYTE: wr_op_of = DM_WR_BYTE;
            SZ_HALF: wr_op_of = DM_WR_HALF;
            default: wr_op_of = DM_WR_WORD;
        endcase
    endfunction

    function automatic logic [2:0] rd_op_of(input logic [1:0] size, input logic sign);
        unique case (size)
            SZ_BYTE: rd_op_of = sign ? DM_RD_LB : DM_RD_LBU;
            SZ_HALF: rd_op_of = sign ? DM_RD_LH : DM_RD_LHU;
            default: rd_op_of = DM_RD_LW;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        misaligned = (size == SZ_RSVD) ||
                     ((size == SZ_HALF) && lsb[0]) ||
                     ((size == SZ_WORD) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dm_arb_if.sv
// Interface dm_arb_if: all request/response and dm-side signals of the arbiter.
//  pN_req/wr/size/sign/addr/wdata : requester N -> arbiter (N = 0 CPU LSU, 1 loader/debug)
//  pN_done/rdata/err              : arbiter -> requester N
//  dm_addr/wr/wr_op/rd_op/wdata   : arbiter -> data memory
//  dm_rdata                       : data memory -> arbiter (combinational read)
// Modports: slave = arbiter side, master = requesters + memory side.
interface dm_arb_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          p0_req;
    logic          p0_wr;
    logic [1:0]    p0_size;
    logic          p0_sign;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_done;
    logic [DW-1:0] p0_rdata;
    logic          p0_err;

    logic          p1_req;
    logic          p1_wr;
    logic [1:0]    p1_size;
    logic          p1_sign;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_done;
    logic [DW-1:0] p1_rdata;
    logic          p1_err;

    logic [AW-1:0] dm_addr;
    logic          dm_wr;
    logic [1:0]    dm_wr_op;
    logic [2:0]    dm_rd_op;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    modport slave (
        input  p0_req, p0_wr, p0_size, p0_sign, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_req, p1_wr, p1_size, p1_sign, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output dm_addr, dm_wr, dm_wr_op, dm_rd_op, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output p0_req, p0_wr, p0_size, p0_sign, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_req, p1_wr, p1_size, p1_sign, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  dm_addr, dm_wr, dm_wr_op, dm_rd_op, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/dm_arb_rr.sv
// dm_arb_rr: two-way round-robin picker.
//  req[1:0] : pending requests
//  last     : port granted most recently
//  gnt      : some request is granted
//  gnt_id   : granted port; on a tie the port that did not win last time
module dm_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = |req;
        gnt_id = 1'b0;
        case (req)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port arbiter/sequencer in front of the byte-addressed data memory.
//  clk, rst : clock; asynchronous active-high reset
//  bus      : dm_arb_if.slave -- requester ports p0/p1 and the dm control/data lines
// One access at a time: IDLE (grant + latch) -> ISSUE (dm access) -> RESP (done pulse).
// Optional build macro DM_ARB_ALIGN_CHECK_EN: misaligned or reserved-size accesses skip
// ISSUE and complete with pN_err=1; without it pN_err is tied 0.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input logic     clk,
    input logic     rst,
    dm_arb_if.slave bus
);

    state_e        state_q, state_d;
    logic          rr_last_q;
    logic          id_q;
    logic          wr_q;
    logic          sign_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          gnt, gnt_id;
    logic          sel_wr, sel_sign;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          bad;

    dm_arb_rr u_rr (
        .req    ({bus.p1_req, bus.p0_req}),
        .last   (rr_last_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_wr    = bus.p0_wr;
        sel_sign  = bus.p0_sign;
        sel_size  = bus.p0_size;
        sel_addr  = bus.p0_addr;
        sel_wdata = bus.p0_wdata;
        if (gnt_id) begin
            sel_wr    = bus.p1_wr;
            sel_sign  = bus.p1_sign;
            sel_size  = bus.p1_size;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt) state_d = bad ? StResp : StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b1;
            id_q      <= 1'b0;
            wr_q      <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && gnt) begin
                rr_last_q <= gnt_id;
                id_q      <= gnt_id;
                wr_q      <= sel_wr;
                sign_q    <= sel_sign;
                size_q    <= sel_size;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
            end
            // Load data is captured at the edge ending ISSUE so it is valid throughout RESP.
            if (state_q == StIssue && !wr_q) begin
                if (id_q) rdata1_q <= bus.dm_rdata;
                else      rdata0_q <= bus.dm_rdata;
            end
        end
    end

`ifdef DM_ARB_ALIGN_CHECK_EN
    logic err0_q, err1_q;

    assign bad = misaligned(sel_size, sel_addr[1:0]);

    // Err changes only on entry to RESP: set on the IDLE->RESP skip, cleared after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else if (state_q == StIdle && gnt && bad) begin
            if (gnt_id) err1_q <= 1'b1;
            else        err0_q <= 1'b1;
        end else if (state_q == StIssue) begin
            if (id_q) err1_q <= 1'b0;
            else      err0_q <= 1'b0;
        end
    end

    assign bus.p0_err = err0_q;
    assign bus.p1_err = err1_q;
`else
    assign bad        = 1'b0;
    assign bus.p0_err = 1'b0;
    assign bus.p1_err = 1'b0;
`endif

    // dm_wr is decoded from the async-reset state so it drops as soon as rst rises.
    assign bus.dm_wr    = (state_q == StIssue) && wr_q;
    assign bus.dm_addr  = addr_q;
    assign bus.dm_wr_op = wr_op_of(size_q);
    assign bus.dm_rd_op = rd_op_of(size_q, sign_q);
    assign bus.dm_wdata = wdata_q;

    assign bus.p0_done  = (state_q == StResp) && !id_q;
    assign bus.p1_done  = (state_q == StResp) && id_q;
    assign bus.p0_rdata = rdata0_q;
    assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: directed accesses with a scoreboard.
// Stimulus tasks push expected completions (per port) and expected dm writes (global);
// a negedge monitor pops and compares whenever a done or dm_wr is seen.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arb_if #(.AW(AW), .DW(DW)) bus ();

    dm_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Simple word memory standing in for dm; no lane handling needed for these vectors.
    logic [DW-1:0] mem [256];
    always @(posedge clk) if (bus.dm_wr) mem[bus.dm_addr[9:2]] <= bus.dm_wdata;
    assign bus.dm_rdata = mem[bus.dm_addr[9:2]];

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic [AW-1:0] addr;
        logic [1:0]    wr_op;
        logic [2:0]    rd_op;
        int            at_cyc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    wr_op;
        logic [DW-1:0] wdata;
    } wr_t;

    exp_t q0[$];
    exp_t q1[$];
    wr_t  wq[$];

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic check_done(input int p);
        exp_t          e;
        logic [DW-1:0] rd;
        logic          er;
        logic          dn;
        if (p == 0) begin
            rd = bus.p0_rdata; er = bus.p0_err; dn = bus.p0_done;
        end else begin
            rd = bus.p1_rdata; er = bus.p1_err; dn = bus.p1_done;
        end
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            chk($sformatf("p%0d unexpected done", p), {63'd0, dn}, 64'd0);
        end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("p%0d rdata", p), {32'd0, rd}, {32'd0, e.rdata});
            chk($sformatf("p%0d err", p), {63'd0, er}, {63'd0, e.err});
            if (e.at_cyc >= 0)
                chk($sformatf("p%0d done cycle", p), 64'(cyc), 64'(e.at_cyc));
            if (!e.err) begin
                chk($sformatf("p%0d dm_addr", p), {54'd0, bus.dm_addr}, {54'd0, e.addr});
                chk($sformatf("p%0d dm_wr_op", p), {62'd0, bus.dm_wr_op}, {62'd0, e.wr_op});
                chk($sformatf("p%0d dm_rd_op", p), {61'd0, bus.dm_rd_op}, {61'd0, e.rd_op});
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            if (bus.p0_done) check_done(0);
            if (bus.p1_done) check_done(1);
            if (bus.dm_wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected dm_wr", {63'd0, bus.dm_wr}, 64'd0);
                end else begin
                    w = wq.pop_front();
                    chk("dm_wr addr", {54'd0, bus.dm_addr}, {54'd0, w.addr});
                    chk("dm_wr wr_op", {62'd0, bus.dm_wr_op}, {62'd0, w.wr_op});
                    chk("dm_wr wdata", {32'd0, bus.dm_wdata}, {32'd0, w.wdata});
                end
            end
        end
    end

    // Presents one access on port p (caller is just after a posedge), waits for its done,
    // and returns just after the following posedge with req dropped unless hold=1.
    task automatic access(input int p, input logic wr, input logic [1:0] size,
                          input logic sign, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                          input logic exp_err, input logic [1:0] exp_wr_op,
                          input logic [2:0] exp_rd_op, input int exp_cyc, input bit hold);
        exp_t e;
        wr_t  w;
        bit   seen;
        e.rdata = exp_rdata; e.err = exp_err; e.addr = addr;
        e.wr_op = exp_wr_op; e.rd_op = exp_rd_op; e.at_cyc = exp_cyc;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (wr && !exp_err) begin
            w.addr = addr; w.wr_op = exp_wr_op; w.wdata = wdata;
            wq.push_back(w);
        end
        if (p == 0) begin
            bus.p0_wr = wr; bus.p0_size = size; bus.p0_sign = sign;
            bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end else begin
            bus.p1_wr = wr; bus.p1_size = size; bus.p1_sign = sign;
            bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (p == 0) ? bus.p0_done : bus.p1_done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL p%0d done timeout: got no done want done @%0h", p, addr);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (p == 0) bus.p0_req = 1'b0;
            else        bus.p1_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        bus.p0_req = 0; bus.p0_wr = 0; bus.p0_size = 0; bus.p0_sign = 0;
        bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_wr = 0; bus.p1_size = 0; bus.p1_sign = 0;
        bus.p1_addr = '0; bus.p1_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", {53'd0, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err,
                           bus.dm_wr, bus.dm_wr_op, bus.dm_rd_op}, 64'd0);
        chk("reset rdata", {bus.p0_rdata, bus.p1_rdata}, 64'd0);
        chk("reset dm bus", {22'd0, bus.dm_addr, bus.dm_wdata}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: store word then load it back on the other port.
        access(0, 1, 2'b10, 0, 10'h010, 32'h11223344, 32'h0, 0, 2'b10, 3'b100, cyc + 2, 0);
        access(1, 0, 2'b10, 0, 10'h010, 32'h0, 32'h11223344, 0, 2'b10, 3'b100, cyc + 2, 0);
        access(1, 1, 2'b10, 0, 10'h020, 32'hA5B6C7D8, 32'h11223344, 0, 2'b10, 3'b100,
               cyc + 2, 0);

        // 2: simultaneous requests; p0 wins, then p0 re-requests against waiting p1 -> p1.
        k = cyc;
        fork
            begin
                access(0, 0, 2'b10, 0, 10'h010, 32'h0, 32'h11223344, 0, 2'b10, 3'b100,
                       k + 2, 1);
                access(0, 0, 2'b10, 0, 10'h020, 32'h0, 32'hA5B6C7D8, 0, 2'b10, 3'b100,
                       k + 8, 0);
            end
            access(1, 0, 2'b10, 0, 10'h020, 32'h0, 32'hA5B6C7D8, 0, 2'b10, 3'b100, k + 5, 0);
        join

        // 3: sub-word loads; rdata is the raw dm word, rd_op carries size/sign.
        access(1, 0, 2'b01, 1, 10'h022, 32'h0, 32'hA5B6C7D8, 0, 2'b01, 3'b011, cyc + 2, 0);
        access(0, 0, 2'b00, 0, 10'h023, 32'h0, 32'hA5B6C7D8, 0, 2'b00, 3'b000, cyc + 2, 0);

        // 4: reset while a store is in ISSUE.
        bus.p0_wr = 1; bus.p0_size = 2'b10; bus.p0_sign = 0;
        bus.p0_addr = 10'h030; bus.p0_wdata = 32'hDEADBEEF; bus.p0_req = 1;
        begin
            wr_t w;
            w.addr = 10'h030; w.wr_op = 2'b10; w.wdata = 32'hDEADBEEF;
            wq.push_back(w);
        end
        @(negedge clk);
        @(negedge clk);
        chk("dm_wr in ISSUE", {63'd0, bus.dm_wr}, 64'd1);
        #1 rst = 1'b1;
        #1 chk("dm_wr async drop", {63'd0, bus.dm_wr}, 64'd0);
        chk("rst clears rdata", {bus.p0_rdata, bus.p1_rdata}, 64'd0);
        bus.p0_req = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        access(0, 1, 2'b10, 0, 10'h030, 32'hDEADBEEF, 32'h0, 0, 2'b10, 3'b100, cyc + 2, 0);
        access(1, 0, 2'b10, 0, 10'h030, 32'h0, 32'hDEADBEEF, 0, 2'b10, 3'b100, cyc + 2, 0);

        // 5: misaligned accesses.
`ifdef DM_ARB_ALIGN_CHECK_EN
        access(0, 1, 2'b10, 0, 10'h012, 32'h0BADF00D, 32'h0, 1, 2'b10, 3'b100, cyc + 1, 0);
        access(1, 0, 2'b01, 1, 10'h021, 32'h0, 32'hDEADBEEF, 1, 2'b01, 3'b011, cyc + 1, 0);
`else
        access(0, 1, 2'b10, 0, 10'h012, 32'h0BADF00D, 32'h0, 0, 2'b10, 3'b100, cyc + 2, 0);
        access(1, 0, 2'b01, 1, 10'h021, 32'h0, 32'hA5B6C7D8, 0, 2'b01, 3'b011, cyc + 2, 0);
`endif

        // 6: p0 back-to-back, one done every 3 cycles.
        k = cyc;
        access(0, 0, 2'b10, 0, 10'h020, 32'h0, 32'hA5B6C7D8, 0, 2'b10, 3'b100, k + 2, 1);
        access(0, 0, 2'b10, 0, 10'h030, 32'h0, 32'hDEADBEEF, 0, 2'b10, 3'b100, k + 5, 1);
        access(0, 0, 2'b10, 0, 10'h020, 32'h0, 32'hA5B6C7D8, 0, 2'b10, 3'b100, k + 8, 1);
        access(0, 0, 2'b10, 0, 10'h030, 32'h0, 32'hDEADBEEF, 0, 2'b10, 3'b100, k + 11, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("p0 queue drained", 64'(q0.size()), 64'd0);
        chk("p1 queue drained", 64'(q1.size()), 64'd0);
        chk("dm_wr queue drained", 64'(wq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
